// File: rtl/lsu_bus_if.sv
// Data-memory bus between the load/store unit and the SoC fabric:
// request/grant for the command phase, rvalid/err for the response phase.
interface lsu_bus_if;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  modport master (
    output req_o, we_o, addr_o, wdata_o, wstrb_o,
    input  gnt_i, rvalid_i, rdata_i, err_i
  );

  modport slave (
    input  req_o, we_o, addr_o, wdata_o, wstrb_o,
    output gnt_i, rvalid_i, rdata_i, err_i
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer: one MEM-stage access at a time onto the data bus,
// holding the pipeline until a one-cycle DONE state releases it.
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        load_done_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  lsu_bus_if.master   bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             load_done_q, load_done_d;
  logic             bus_err_q, bus_err_d;

  logic        access_req;
  logic        fault;
  logic [31:0] load_ext;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new;

  assign access_req = mem_read_i | mem_write_i;
  assign fault = (funct3_i[1:0] == 2'b11) || (funct3_i[2:1] == 2'b11) ||
                 ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  // Store lane placement; loads carry no strobes.
  always_comb begin
    wstrb_new = 4'b0000;
    wdata_new = wdata_i;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          wstrb_new = 4'b0001 << addr_i[1:0];
          wdata_new = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          wstrb_new = 4'b0011 << addr_i[1:0];
          wdata_new = {2{wdata_i[15:0]}};
        end
        default: wstrb_new = 4'b1111;
      endcase
    end
  end

  // Load lane extraction from the latched access, funct3[2] selects zero-extension.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = bus.rdata_i[8*addr_q[1:0] +: 8];
    half_sel = addr_q[1] ? bus.rdata_i[31:16] : bus.rdata_i[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_ext = bus.rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    load_done_d  = 1'b0;
    bus_err_d    = 1'b0;
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    bus.req_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access_req) begin
          if (fault) begin
            misaligned_o = 1'b1;
          end else begin
            stall_o  = 1'b1;
            addr_d   = addr_i;
            wdata_d  = wdata_new;
            wstrb_d  = wstrb_new;
            funct3_d = funct3_i;
            we_d     = mem_write_i;
            cnt_d    = '0;
            state_d  = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT_RSP: begin
        stall_o   = 1'b1;
        bus.req_o = (state_q == S_REQ);
        cnt_d     = cnt_q + CNT_W'(1);
        // A response in REQ only counts when it arrives together with the grant.
        if (bus.rvalid_i && (state_q == S_WAIT_RSP || bus.gnt_i)) begin
          state_d = S_DONE;
          if (bus.err_i) begin
            bus_err_d = 1'b1;
          end else if (!we_q) begin
            rdata_d     = load_ext;
            load_done_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else if (state_q == S_REQ && bus.gnt_i) begin
          state_d = S_WAIT_RSP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      load_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      load_done_q <= load_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.addr_o  = {addr_q[31:2], 2'b00};
  assign bus.wdata_o = wdata_q;
  assign bus.we_o    = we_q & (state_q == S_REQ);
  assign bus.wstrb_o = (state_q == S_REQ) ? wstrb_q : 4'b0000;
  assign rdata_o     = rdata_q;
  assign load_done_o = load_done_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: loads, stores, faults, bus errors,
// timeout and reset mid-access against hand-computed expectations.
module tb_lsu_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        load_done_o;
  logic        misaligned_o;
  logic        bus_err_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_rdata = '0;

  lsu_bus_if bus();

  lsu_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .load_done_o(load_done_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.err_i = 1'b0; bus.rdata_i = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_idle();
    tick(); tick();
    n_vec++; if ({stall_o, load_done_o, misaligned_o, bus_err_o, bus.req_o, bus.we_o} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000", {stall_o, load_done_o, misaligned_o, bus_err_o, bus.req_o, bus.we_o}); n_err++; end
    n_vec++; if ({rdata_o, bus.addr_o, bus.wdata_o, bus.wstrb_o} !== 100'b0) begin
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%b want all 0", rdata_o, bus.addr_o, bus.wdata_o, bus.wstrb_o); n_err++; end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  // Zero-wait load; MEM inputs stay asserted through DONE to show they are ignored there.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp, input string name);
    mem_read_i = 1'b1; funct3_i = f3; addr_i = a;
    #1;
    n_vec++; if (stall_o !== 1'b1 || bus.req_o !== 1'b0) begin
      $display("FAIL %s_idle: stall=%b req=%b want stall=1 req=0", name, stall_o, bus.req_o); n_err++; end
    tick();
    n_vec++; if (bus.req_o !== 1'b1 || stall_o !== 1'b1 || bus.addr_o !== {a[31:2], 2'b00} || bus.we_o !== 1'b0 || bus.wstrb_o !== 4'b0) begin
      $display("FAIL %s_req: req=%b stall=%b addr=%h we=%b wstrb=%b want 1 1 %h 0 0000", name, bus.req_o, stall_o, bus.addr_o, bus.we_o, bus.wstrb_o, {a[31:2], 2'b00}); n_err++; end
    bus.gnt_i = 1'b1; bus.rvalid_i = 1'b1; bus.rdata_i = rd;
    tick();
    bus_idle();
    n_vec++; if (stall_o !== 1'b0 || load_done_o !== 1'b1 || rdata_o !== exp || bus.req_o !== 1'b0) begin
      $display("FAIL %s_done: stall=%b done=%b rdata=%h req=%b want 0 1 %h 0", name, stall_o, load_done_o, rdata_o, bus.req_o, exp); n_err++; end
    last_rdata = exp;
    tick();
    mem_read_i = 1'b0;
    n_vec++; if (bus.req_o !== 1'b0 || load_done_o !== 1'b0 || rdata_o !== exp) begin
      $display("FAIL %s_after: req=%b done=%b rdata=%h want 0 0 %h", name, bus.req_o, load_done_o, rdata_o, exp); n_err++; end
    $display("load %s f3=%b addr=%h bus=%h -> rdata_o=%h", name, f3, a, rd, rdata_o);
  endtask

  task automatic test_zero_wait_load;
    do_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, "lw");
  endtask

  task automatic test_load_extend;
    do_load(3'b000, 32'h103, 32'h80FF_0000, 32'hFFFFFF80, "lb");
    do_load(3'b100, 32'h103, 32'h80FF_0000, 32'h00000080, "lbu");
    do_load(3'b001, 32'h102, 32'h80FF_0000, 32'hFFFF80FF, "lh");
    do_load(3'b101, 32'h102, 32'h80FF_0000, 32'h000080FF, "lhu");
    do_load(3'b000, 32'h101, 32'h12345678, 32'h00000056, "lb1");
    do_load(3'b001, 32'h100, 32'h1234F678, 32'hFFFFF678, "lh0");
  endtask

  task automatic test_store;
    mem_write_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h202; wdata_i = 32'h1234ABCD;
    #1;
    n_vec++; if (stall_o !== 1'b1) begin $display("FAIL sh_idle: stall=%b want 1", stall_o); n_err++; end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.req_o !== 1'b1 || bus.addr_o !== 32'h200 || bus.wstrb_o !== 4'b1100 || bus.wdata_o !== 32'hABCDABCD || bus.we_o !== 1'b1 || stall_o !== 1'b1) begin
        $display("FAIL sh_hold%0d: req=%b addr=%h wstrb=%b wdata=%h we=%b stall=%b want 1 200 1100 abcdabcd 1 1", i, bus.req_o, bus.addr_o, bus.wstrb_o, bus.wdata_o, bus.we_o, stall_o); n_err++; end
      tick();
    end
    bus.gnt_i = 1'b1;
    n_vec++; if (bus.req_o !== 1'b1 || bus.wstrb_o !== 4'b1100) begin
      $display("FAIL sh_gnt: req=%b wstrb=%b want 1 1100", bus.req_o, bus.wstrb_o); n_err++; end
    tick();
    bus.gnt_i = 1'b0;
    n_vec++; if (bus.req_o !== 1'b0 || stall_o !== 1'b1) begin
      $display("FAIL sh_wait: req=%b stall=%b want 0 1", bus.req_o, stall_o); n_err++; end
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h5555AAAA;
    tick();
    bus_idle();
    n_vec++; if (stall_o !== 1'b0 || load_done_o !== 1'b0 || bus_err_o !== 1'b0 || rdata_o !== last_rdata) begin
      $display("FAIL sh_done: stall=%b done=%b err=%b rdata=%h want 0 0 0 %h", stall_o, load_done_o, bus_err_o, rdata_o, last_rdata); n_err++; end
    mem_write_i = 1'b0;
    tick();
    $display("store sh addr=202 wdata=1234abcd -> wstrb=1100 wdata_o=abcdabcd");

    mem_write_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h201; wdata_i = 32'h000000EF;
    tick();
    n_vec++; if (bus.wstrb_o !== 4'b0010 || bus.wdata_o !== 32'hEFEFEFEF || bus.we_o !== 1'b1) begin
      $display("FAIL sb_req: wstrb=%b wdata=%h we=%b want 0010 efefefef 1", bus.wstrb_o, bus.wdata_o, bus.we_o); n_err++; end
    bus.gnt_i = 1'b1; bus.rvalid_i = 1'b1;
    tick();
    bus_idle(); mem_write_i = 1'b0;
    n_vec++; if (stall_o !== 1'b0 || load_done_o !== 1'b0) begin
      $display("FAIL sb_done: stall=%b done=%b want 0 0", stall_o, load_done_o); n_err++; end
    tick();
    $display("store sb addr=201 wdata=ef -> wstrb=0010 wdata_o=efefefef");
  endtask

  task automatic test_fault;
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b110};
    logic [31:0] as  [4] = '{32'h101, 32'h100, 32'h103, 32'h100};
    for (int i = 0; i < 4; i++) begin
      mem_read_i = 1'b1; funct3_i = f3s[i]; addr_i = as[i];
      #1;
      n_vec++; if (misaligned_o !== 1'b1 || stall_o !== 1'b0) begin
        $display("FAIL fault%0d: misaligned=%b stall=%b want 1 0", i, misaligned_o, stall_o); n_err++; end
      tick();
      n_vec++; if (bus.req_o !== 1'b0 || stall_o !== 1'b0) begin
        $display("FAIL fault%0d_nobus: req=%b stall=%b want 0 0", i, bus.req_o, stall_o); n_err++; end
      $display("fault f3=%b addr=%h -> misaligned_o=%b", f3s[i], as[i], misaligned_o);
    end
    mem_read_i = 1'b0;
    #1;
    n_vec++; if (misaligned_o !== 1'b0) begin $display("FAIL fault_clear: misaligned=%b want 0", misaligned_o); n_err++; end
  endtask

  task automatic test_bus_error;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
    tick();
    bus.gnt_i = 1'b1;
    tick();
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b1; bus.err_i = 1'b1; bus.rdata_i = 32'h0BADF00D;
    tick();
    bus_idle(); mem_read_i = 1'b0;
    n_vec++; if (bus_err_o !== 1'b1 || load_done_o !== 1'b0 || rdata_o !== last_rdata || stall_o !== 1'b0) begin
      $display("FAIL buserr_done: err=%b done=%b rdata=%h stall=%b want 1 0 %h 0", bus_err_o, load_done_o, rdata_o, stall_o, last_rdata); n_err++; end
    tick();
    n_vec++; if (bus_err_o !== 1'b0) begin $display("FAIL buserr_pulse: err=%b want 0", bus_err_o); n_err++; end
    $display("load with err_i -> bus_err_o pulse, rdata_o=%h kept", rdata_o);
  endtask

  task automatic test_timeout;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (bus.req_o !== 1'b1 || bus_err_o !== 1'b0) begin
        $display("FAIL timeout_req%0d: req=%b err=%b want 1 0", i, bus.req_o, bus_err_o); n_err++; end
      tick();
    end
    mem_read_i = 1'b0;
    n_vec++; if (bus.req_o !== 1'b0 || bus_err_o !== 1'b1 || load_done_o !== 1'b0 || stall_o !== 1'b0) begin
      $display("FAIL timeout_done: req=%b err=%b done=%b stall=%b want 0 1 0 0", bus.req_o, bus_err_o, load_done_o, stall_o); n_err++; end
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h00000055;
    tick();
    bus_idle();
    n_vec++; if (load_done_o !== 1'b0 || bus_err_o !== 1'b0 || rdata_o !== last_rdata) begin
      $display("FAIL timeout_late: done=%b err=%b rdata=%h want 0 0 %h", load_done_o, bus_err_o, rdata_o, last_rdata); n_err++; end
    $display("timeout after 8 REQ cycles -> bus_err_o pulse, late rvalid ignored");
  endtask

  task automatic test_reset_mid_access;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
    tick();
    bus.gnt_i = 1'b1;
    tick();
    bus.gnt_i = 1'b0;
    n_vec++; if (bus.req_o !== 1'b0 || stall_o !== 1'b1) begin
      $display("FAIL midrst_wait: req=%b stall=%b want 0 1", bus.req_o, stall_o); n_err++; end
    reset = 1'b1; mem_read_i = 1'b0;
    tick();
    reset = 1'b0;
    n_vec++; if ({stall_o, load_done_o, misaligned_o, bus_err_o, bus.req_o, bus.we_o, rdata_o, bus.addr_o} !== 70'b0) begin
      $display("FAIL midrst_idle: stall=%b done=%b err=%b req=%b rdata=%h addr=%h want all 0", stall_o, load_done_o, bus_err_o, bus.req_o, rdata_o, bus.addr_o); n_err++; end
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'hCAFEF00D;
    tick();
    bus_idle();
    n_vec++; if (load_done_o !== 1'b0 || bus.req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0) begin
      $display("FAIL midrst_late: done=%b req=%b stall=%b rdata=%h want 0 0 0 0", load_done_o, bus.req_o, stall_o, rdata_o); n_err++; end
    last_rdata = '0;
    $display("reset in WAIT_RSP -> idle, late rvalid ignored");
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_zero_wait_load();
    test_load_extend();
    test_store();
    test_fault();
    test_bus_error();
    test_timeout();
    test_reset_mid_access();
    do_load(3'b010, 32'h104, 32'h01020304, 32'h01020304, "lw_post");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
